bank_scheduler: RTL

Per-bank command sequencer for the DDR bank emulation model.
- Accepts one read/write request at a time from the channel front-end.
- Drives the bank's 19-bit one-hot command vector, row and column, inserting PR/ACT as needed and honouring tRP, tRCD, the burst length and tRFC.
- Uses an open-page policy, with periodic refresh forced every tREFI cycles.

---
 rtl/bank_pkg.sv | 45 ++++
 rtl/bank_wait_ctr.sv | 29 ++
 rtl/bank_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the DDR bank command sequencer: command bit
// positions, sequencer states and default timing values.
package bank_pkg;

   // One-hot command vector layout
   localparam int CMD_W   = 19;
   localparam int CMD_ACT = 18;
   localparam int CMD_PR  = 7;
   localparam int CMD_RD  = 5;
   localparam int CMD_REF = 3;
   localparam int CMD_WR  = 1;
   localparam int CMD_WRA = 0;

   // Default bank geometry and timing (in clk cycles)
   localparam int DEF_ROWS  = 131072;
   localparam int DEF_COLS  = 1024;
   localparam int DEF_BL    = 8;
   localparam int DEF_TRP   = 3;
   localparam int DEF_TRCD  = 3;
   localparam int DEF_TRFC  = 16;
   localparam int DEF_TREFI = 780;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE,
      ST_PRE_WAIT,
      ST_ACT,
      ST_ACT_WAIT,
      ST_CAS,
      ST_BURST,
      ST_REF,
      ST_REF_WAIT
   } state_t;

   // Largest of four timing values, used to size the shared wait counter
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/bank_wait_ctr.sv
// Loadable down-counter shared by every timed wait state of the bank
// sequencer. It holds while halted and flags the last cycle of a wait.
module bank_wait_ctr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         halt,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Load on entry to a wait state, otherwise count down to zero and stop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (!halt && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bank_scheduler.sv
// Per-bank command sequencer. Takes one read/write request at a time,
// opens/closes rows as needed (open-page policy), issues RD/WR and holds
// the bank busy for the burst, and forces a refresh every TREFI cycles.
module bank_scheduler
   import bank_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int BL    = DEF_BL,
   parameter int TRP   = DEF_TRP,
   parameter int TRCD  = DEF_TRCD,
   parameter int TRFC  = DEF_TRFC,
   parameter int TREFI = DEF_TREFI
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      halt,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [$clog2(ROWS)-1:0]   req_row,
   input  logic [$clog2(COLS)-1:0]   req_col,
   output logic [CMD_W-1:0]          commands,
   output logic [$clog2(ROWS)-1:0]   row,
   output logic [$clog2(COLS)-1:0]   column,
   output logic                      busy,
   output logic                      done,
   output logic                      open_valid
);

   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);
   localparam int WAIT_W = $clog2(max4(TRP, TRCD, TRFC, BL) + 1);
   localparam int REFI_W = $clog2(TREFI + 1);

   // Wait counters are loaded with (cycles in state - 1); the zero flag
   // marks the final cycle of the state.
   localparam logic [WAIT_W-1:0] TRP_LD  = WAIT_W'((TRP  > 1) ? TRP  - 2 : 0);
   localparam logic [WAIT_W-1:0] TRCD_LD = WAIT_W'((TRCD > 1) ? TRCD - 2 : 0);
   localparam logic [WAIT_W-1:0] TRFC_LD = WAIT_W'((TRFC > 1) ? TRFC - 2 : 0);
   localparam logic [WAIT_W-1:0] BL_LD   = WAIT_W'((BL   > 0) ? BL   - 1 : 0);
   localparam logic [REFI_W-1:0] REFI_RELOAD = REFI_W'(TREFI - 1);

   state_t              state;
   state_t              state_next;
   logic [CMD_W-1:0]    cmd_q;
   logic                lat_write;
   logic [ROW_W-1:0]    lat_row;
   logic [COL_W-1:0]    lat_col;
   logic                ref_flag;
   logic                ref_go_pre;
   logic [REFI_W-1:0]   ref_cnt;
   logic                ref_pending;
   logic                accept;
   logic                ctr_load;
   logic [WAIT_W-1:0]   ctr_val;
   logic                ctr_zero;
   logic                nxt_write;
   logic [ROW_W-1:0]    nxt_row;
   logic [COL_W-1:0]    nxt_col;

   // Command bit a state issues during its (single) non-halted cycle
   function automatic logic [CMD_W-1:0] cmd_of(input state_t s, input logic wr);
      logic [CMD_W-1:0] c;
      c = '0;
      case (s)
         ST_PRE: c[CMD_PR]  = 1'b1;
         ST_ACT: c[CMD_ACT] = 1'b1;
         ST_REF: c[CMD_REF] = 1'b1;
         ST_CAS: begin
            if (wr) c[CMD_WR] = 1'b1;
            else    c[CMD_RD] = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   bank_wait_ctr #(
      .W (WAIT_W)
   ) u_wait_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .halt     (halt),
      .load     (ctr_load),
      .load_val (ctr_val),
      .zero     (ctr_zero)
   );

   assign ref_pending = (ref_cnt == '0);

   // Request fields come straight from the port on the accept cycle and
   // from the latches afterwards.
   assign nxt_write = (state == ST_IDLE) ? req_write : lat_write;
   assign nxt_row   = (state == ST_IDLE) ? req_row   : lat_row;
   assign nxt_col   = (state == ST_IDLE) ? req_col   : lat_col;

   // Command register is gated by halt so a stalled command issues later
   assign commands = halt ? '0 : cmd_q;
   assign busy     = (state != ST_IDLE);

   // Next-state decode, wait-counter loads, handshake and done pulse
   always_comb begin
      state_next = state;
      ctr_load   = 1'b0;
      ctr_val    = '0;
      accept     = 1'b0;
      ref_go_pre = 1'b0;
      req_ready  = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            // reset_n is included so ready is low while reset is held
            req_ready = reset_n && !ref_pending && !halt;
            if (!halt) begin
               if (ref_pending) begin
                  if (open_valid) begin
                     state_next = ST_PRE;
                     ref_go_pre = 1'b1;
                  end else begin
                     state_next = ST_REF;
                  end
               end else if (req_valid) begin
                  accept = 1'b1;
                  if (!open_valid)          state_next = ST_ACT;
                  else if (row == req_row)  state_next = ST_CAS;
                  else                      state_next = ST_PRE;
               end
            end
         end
         ST_PRE: begin
            if (!halt) begin
               if (TRP > 1) begin
                  state_next = ST_PRE_WAIT;
                  ctr_load   = 1'b1;
                  ctr_val    = TRP_LD;
               end else begin
                  state_next = ref_flag ? ST_REF : ST_ACT;
               end
            end
         end
         ST_PRE_WAIT: begin
            if (!halt && ctr_zero) state_next = ref_flag ? ST_REF : ST_ACT;
         end
         ST_ACT: begin
            if (!halt) begin
               if (TRCD > 1) begin
                  state_next = ST_ACT_WAIT;
                  ctr_load   = 1'b1;
                  ctr_val    = TRCD_LD;
               end else begin
                  state_next = ST_CAS;
               end
            end
         end
         ST_ACT_WAIT: begin
            if (!halt && ctr_zero) state_next = ST_CAS;
         end
         ST_CAS: begin
            if (!halt) begin
               state_next = ST_BURST;
               ctr_load   = 1'b1;
               ctr_val    = BL_LD;
            end
         end
         ST_BURST: begin
            if (!halt && ctr_zero) begin
               done       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_REF: begin
            if (!halt) begin
               if (TRFC > 1) begin
                  state_next = ST_REF_WAIT;
                  ctr_load   = 1'b1;
                  ctr_val    = TRFC_LD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_REF_WAIT: begin
            if (!halt && ctr_zero) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Command/address registers, request latches and open-row tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q      <= '0;
         row        <= '0;
         column     <= '0;
         lat_write  <= 1'b0;
         lat_row    <= '0;
         lat_col    <= '0;
         open_valid <= 1'b0;
         ref_flag   <= 1'b0;
      end else if (!halt) begin
         cmd_q <= cmd_of(state_next, nxt_write);
         if (accept) begin
            lat_write <= req_write;
            lat_row   <= req_row;
            lat_col   <= req_col;
         end
         // row doubles as the open-row register used for hit detection
         if (state_next == ST_ACT) row    <= nxt_row;
         if (state_next == ST_CAS) column <= nxt_col;
         if (state == ST_ACT)      open_valid <= 1'b1;
         else if (state == ST_PRE) open_valid <= 1'b0;
         if (ref_go_pre)           ref_flag <= 1'b1;
         else if (state == ST_REF) ref_flag <= 1'b0;
      end
   end

   // Refresh interval counter: saturates at zero, reloads when REF issues
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ref_cnt <= REFI_RELOAD;
      end else if (!halt) begin
         if (state == ST_REF)        ref_cnt <= REFI_RELOAD;
         else if (ref_cnt != '0)     ref_cnt <= ref_cnt - 1'b1;
      end
   end

endmodule
